// File: rtl/mux_nx1_rr.sv
//----------------------------------------------------------------------------
// mux_nx1_rr : N-channel registered mux, manual or round-robin grant, valid/ready
// Revision   : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mux_nx1_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel_in,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int             C_SW1  = SEL_W + 1;
   localparam logic [SEL_W:0] C_N    = C_SW1'(N);
   localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;

   logic [N-1:0]     w_man_oh;
   logic [SEL_W-1:0] w_man_idx;
   logic             w_man_vld;

   logic [N-1:0]     w_rr_oh;
   logic [SEL_W-1:0] w_rr_idx;
   logic             w_rr_vld;
   logic [SEL_W:0]   w_rr_scan;

   logic [N-1:0]     w_grant_oh;
   logic [SEL_W-1:0] w_grant_idx;
   logic             w_grant_vld;
   logic [WIDTH-1:0] w_grant_data;

   logic             w_can_load;
   logic             w_xfer;

   // Matching against each legal index means an out-of-range sel_in simply grants nothing.
   always_comb begin
      w_man_oh  = '0;
      w_man_idx = '0;
      w_man_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel_in == SEL_W'(i) && in_valid[i]) begin
            w_man_oh[i] = 1'b1;
            w_man_idx   = SEL_W'(i);
            w_man_vld   = 1'b1;
         end
      end
   end

   always_comb begin
      w_rr_oh   = '0;
      w_rr_idx  = '0;
      w_rr_vld  = 1'b0;
      w_rr_scan = '0;
      for (int k = 0; k < N; k++) begin
         w_rr_scan = {1'b0, r_ptr} + C_SW1'(k);
         if (w_rr_scan >= C_N) begin
            w_rr_scan = w_rr_scan - C_N;
         end
         if (!w_rr_vld && in_valid[w_rr_scan[SEL_W-1:0]]) begin
            w_rr_oh[w_rr_scan[SEL_W-1:0]] = 1'b1;
            w_rr_idx                      = w_rr_scan[SEL_W-1:0];
            w_rr_vld                      = 1'b1;
         end
      end
   end

   always_comb begin
      w_grant_oh  = mode ? w_rr_oh  : w_man_oh;
      w_grant_idx = mode ? w_rr_idx : w_man_idx;
      w_grant_vld = mode ? w_rr_vld : w_man_vld;
   end

   always_comb begin
      w_grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant_oh[i]) begin
            w_grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_can_load = (r_state == ST_EMPTY) || out_ready;
   assign w_xfer     = w_grant_vld && w_can_load && !rst;
   assign in_ready   = w_grant_oh & {N{w_can_load && !rst}};

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ST_EMPTY: begin
            if (w_xfer) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (!w_xfer && out_ready) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (w_xfer && mode) begin
         w_ptr_nxt = (w_grant_idx == C_LAST) ? '0 : w_grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_ptr      <= '0;
         r_out_data <= '0;
         r_out_sel  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         if (w_xfer) begin
            r_out_data <= w_grant_data;
            r_out_sel  <= w_grant_idx;
         end
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on every channel and on the output. It supports two modes: manual (select-driven) and round-robin (fair scan of valid channels). It is the sequential, multi-channel generalisation of the team's 4x1 select-driven mux, and it forwards one granted channel per cycle into a single downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N), width of the select and pointer fields; derived, not to be overridden.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- mode, input, 1, selection mode: 0 = manual, 1 = round-robin.
- sel_in, input, SEL_W, manual-mode channel select.
- in_data, input, N*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N, per-channel valid.
- in_ready, output, N, per-channel accept; one-hot or zero.
- out_data, output, WIDTH, registered selected data.
- out_sel, output, SEL_W, channel index of the current out_data.
- out_valid, output, 1, out_data holds an unconsumed word.
- out_ready, input, 1, downstream accept.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready forced to 0 while rst=1.
  - Any word in flight is discarded.
- Output stage is a single register with two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = !out_valid || out_ready (combinational).
- Grant selection (combinational, evaluated each cycle):
  - Manual (mode=0):
    - g = sel_in if sel_in < N and in_valid[sel_in]=1; otherwise no grant.
    - sel_in >= N (N not a power of 2) produces no grant and no error.
  - Round-robin (mode=1):
    - g = first i with in_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
    - No valid channel produces no grant.
- in_ready[g] = can_load when a grant exists; all other in_ready bits are 0. in_ready never depends on the same channel's in_valid except through the grant.
- Transfer on a channel: in_valid[g] && in_ready[g].
  - Next cycle: out_data = in_data[g], out_sel = g, out_valid = 1.
  - Latency is exactly 1 cycle, input handshake to out_valid.
- Output handshake:
  - out_valid && out_ready consumes the word.
  - With a simultaneous new transfer: stays FULL with the new word, giving full throughput of 1 word/cycle.
  - Without a new transfer: goes EMPTY.
- While FULL and out_ready=0:
  - out_data and out_sel stay stable.
  - All in_ready bits are 0.
- ptr update: only on a transfer in round-robin mode, ptr = (g+1) mod N with explicit wrap, including from N-1 to 0.
  - ptr is not touched in manual mode.
  - A mode change does not reset ptr.
- A mode or sel_in change takes effect on the same-cycle grant. Words already registered are unaffected.
- Inputs with in_valid=0 carry don't-care data; out_data never changes without a transfer.
- Reset asserted while FULL: the word is dropped and out_valid=0 on the next cycle regardless of out_ready.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles with all in_valid=1.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=0; after release, the first grant in round-robin mode is channel 0.
- Manual select:
  - Stimulus: N=4, mode=0, sel_in=2, in_data ch2=8'hA5, in_valid=4'b1111, out_ready=1.
  - Required: in_ready=4'b0100; the next cycle gives out_data=8'hA5, out_sel=2, out_valid=1; sel_in=2 with in_valid[2]=0 gives in_ready=0.
- Round-robin fairness and wrap:
  - Stimulus: mode=1, in_valid=4'b1111 constant, out_ready=1, channel i data = 8'h10+i.
  - Required: out_sel sequence 0,1,2,3,0,1; out_valid high every cycle after the first.
- Round-robin skip:
  - Stimulus: in_valid=4'b1001, starting at ptr=1.
  - Required: grants 3, 0, 3, 0.
- Backpressure:
  - Stimulus: FULL with out_sel=1, out_ready=0 for 5 cycles.
  - Required: out_data/out_sel stable, in_ready=0, ptr unchanged; out_ready=1 resumes with the next grant in the same cycle.
- Mid-operation reset and non-power-of-2 N:
  - Stimulus: with N=3, sel_in=3 in manual mode; separately, rst pulsed while FULL.
  - Required: sel_in=3 gives no grant; the rst pulse gives out_valid=0 on the next cycle and ptr=0.
